// File: rtl/if_fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl_if
//
// SRAM-like instruction bus between the fetch controller (master) and the
// instruction memory (slave).
//
//   inst_req      master -> slave  request valid, held until inst_addr_ok
//   inst_addr     master -> slave  request address, stable while inst_req
//   inst_addr_ok  slave  -> master request accepted this cycle
//   inst_data_ok  slave  -> master read data valid this cycle
//   inst_rdata    slave  -> master read data
// -----------------------------------------------------------------------------
interface if_fetch_ctrl_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// if_fetch_ctrl
//
// Instruction-fetch stage controller. Owns the program counter, issues one
// instruction-bus request at a time and holds the returned instruction until
// the IF/ID register consumes it. Applies delayed-branch redirects (after the
// delay slot) and exception/ERET flushes.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   stall                IF/ID is holding, the current slot is not consumed
//   flush, flush_target  discard everything in IF, restart at flush_target
//   redirect, redirect_target
//                        branch resolved in ID; takes effect on the fetch
//                        that follows the delay slot
//   bus (master)         SRAM-like req/addr_ok/data_ok instruction bus
//   if_valid             output slot holds a fetched instruction
//   if_pc                PC of the slot
//   if_inst              instruction word (0 on address error)
//   if_addr_error        PC misaligned, no bus request was made
//   if_inst_req          a bus request was issued for this slot
// -----------------------------------------------------------------------------
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [31:0]            flush_target,
    input  logic                   redirect,
    input  logic [31:0]            redirect_target,
    if_fetch_ctrl_if.master        bus,
    output logic                   if_valid,
    output logic [31:0]            if_pc,
    output logic [31:0]            if_inst,
    output logic                   if_addr_error,
    output logic                   if_inst_req
);

    typedef enum logic [1:0] {
        S_IDLE,   // ready to issue the fetch for pc_q
        S_ADDR,   // inst_req high, waiting for addr_ok
        S_DATA,   // request accepted, waiting for data_ok
        S_HOLD    // slot valid, waiting for IF/ID to take it
    } state_t;

    state_t      state_q,    state_d;
    logic [31:0] pc_q,       pc_d;
    logic        req_q,      req_d;
    logic [31:0] addr_q,     addr_d;
    logic        discard_q,  discard_d;
    logic        pend_q,     pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;

    logic        valid_q,    valid_d;
    logic [31:0] slot_pc_q,  slot_pc_d;
    logic [31:0] inst_q,     inst_d;
    logic        err_q,      err_d;
    logic        ireq_q,     ireq_d;

    logic [31:0] seq_pc;

    // PC that follows the slot being consumed. A redirect arriving in the very
    // cycle the delay slot leaves IF is still meant for the next fetch, so it
    // bypasses the pending register.
    always_comb begin
        if (redirect) begin
            seq_pc = redirect_target;
        end else if (pend_q) begin
            seq_pc = pend_tgt_q;
        end else begin
            seq_pc = pc_q + 32'd4;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        discard_d  = discard_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        valid_d    = valid_q;
        slot_pc_d  = slot_pc_q;
        inst_d     = inst_q;
        err_d      = err_q;
        ireq_d     = ireq_q;

        // The redirect never touches the in-flight or held slot: that slot is
        // the delay slot. It is only remembered until that slot is consumed.
        // A simultaneous flush wins and the redirect is lost.
        if (flush) begin
            pend_d = 1'b0;
        end else if (redirect) begin
            pend_d     = 1'b1;
            pend_tgt_d = redirect_target;
        end

        unique case (state_q)
            S_IDLE: begin
                if (flush) begin
                    pc_d = flush_target;
                end else if (pc_q[1:0] == 2'b00) begin
                    state_d = S_ADDR;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end else begin
                    // Misaligned PC: deliver an error slot without touching
                    // the bus.
                    state_d   = S_HOLD;
                    valid_d   = 1'b1;
                    slot_pc_d = pc_q;
                    inst_d    = 32'h0;
                    err_d     = 1'b1;
                    ireq_d    = 1'b0;
                end
            end

            S_ADDR: begin
                // An issued address cannot be withdrawn; a flush here only
                // marks the eventual data as stale.
                if (flush) begin
                    pc_d      = flush_target;
                    discard_d = 1'b1;
                end
                if (bus.inst_addr_ok) begin
                    state_d = S_DATA;
                    req_d   = 1'b0;
                end
            end

            S_DATA: begin
                if (flush) begin
                    pc_d = flush_target;
                end
                if (bus.inst_data_ok) begin
                    if (flush || discard_q) begin
                        state_d   = S_IDLE;
                        discard_d = 1'b0;
                    end else begin
                        state_d   = S_HOLD;
                        valid_d   = 1'b1;
                        slot_pc_d = pc_q;
                        inst_d    = bus.inst_rdata;
                        err_d     = 1'b0;
                        ireq_d    = 1'b1;
                    end
                end else if (flush) begin
                    discard_d = 1'b1;
                end
            end

            S_HOLD: begin
                if (flush) begin
                    state_d = S_IDLE;
                    pc_d    = flush_target;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    state_d = S_IDLE;
                    pc_d    = seq_pc;
                    pend_d  = 1'b0;
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            discard_q  <= 1'b0;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'h0;
            valid_q    <= 1'b0;
            slot_pc_q  <= 32'h0;
            inst_q     <= 32'h0;
            err_q      <= 1'b0;
            ireq_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            discard_q  <= discard_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            valid_q    <= valid_d;
            slot_pc_q  <= slot_pc_d;
            inst_q     <= inst_d;
            err_q      <= err_d;
            ireq_q     <= ireq_d;
        end
    end

    assign bus.inst_req  = req_q;
    assign bus.inst_addr = addr_q;

    assign if_valid      = valid_q;
    assign if_pc         = slot_pc_q;
    assign if_inst       = inst_q;
    assign if_addr_error = err_q;
    assign if_inst_req   = ireq_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_ctrl
//
// Directed scenarios followed by a randomized run. The bench plays the
// instruction memory (data is a fixed function of the accepted address) and
// keeps a fetch-stream model: the PC the controller should be fetching, plus a
// pending branch target.
// -----------------------------------------------------------------------------
module tb_if_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] flush_target;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_addr_error;
    logic        if_inst_req;

    if_fetch_ctrl_if bus ();

    if_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .flush_target    (flush_target),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .bus             (bus),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .if_addr_error   (if_addr_error),
        .if_inst_req     (if_inst_req)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // memory responder state
    logic        outst;
    logic [31:0] outst_addr;
    int          req_age;
    int          data_age;
    int          ad_dly;
    int          dd_dly;
    bit          rand_mode;
    bit          spur_once;

    // fetch-stream model
    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_pt;

    int          slots;
    int          gap;
    int          max_gap;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic        p_rst, p_req, p_aok, p_dok, p_valid, p_stall, p_flush, p_redir;
        logic        p_err, p_ireq;
        logic [31:0] p_addr, p_ft, p_rt, p_pc, p_inst;
        logic        e_err;

        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        if (outst && data_age >= dd_dly) begin
            bus.inst_data_ok = 1'b1;
            bus.inst_rdata   = mem(outst_addr);
        end else if (!outst && bus.inst_req !== 1'b1 &&
                     (spur_once || (rand_mode && $urandom_range(0, 7) == 0))) begin
            bus.inst_data_ok = 1'b1;
            bus.inst_rdata   = 32'hDEAD_BEEF;
        end
        spur_once = 1'b0;
        if (bus.inst_req === 1'b1 && req_age >= ad_dly) bus.inst_addr_ok = 1'b1;

        p_rst   = reset;
        p_req   = bus.inst_req;
        p_addr  = bus.inst_addr;
        p_aok   = bus.inst_addr_ok;
        p_dok   = bus.inst_data_ok;
        p_valid = if_valid;
        p_stall = stall;
        p_flush = flush;
        p_ft    = flush_target;
        p_redir = redirect;
        p_rt    = redirect_target;
        p_pc    = if_pc;
        p_inst  = if_inst;
        p_err   = if_addr_error;
        p_ireq  = if_inst_req;

        @(posedge clk);
        #1;

        if (p_rst) begin
            m_pc     = RESET_PC;
            m_pend   = 1'b0;
            outst    = 1'b0;
            req_age  = 0;
            data_age = 0;
        end else begin
            if (p_dok && outst) outst = 1'b0;
            if (p_aok) begin
                outst      = 1'b1;
                outst_addr = p_addr;
                data_age   = 0;
                req_age    = 0;
                if (rand_mode) begin
                    ad_dly = $urandom_range(0, 3);
                    dd_dly = $urandom_range(0, 3);
                end
            end else begin
                if (outst) data_age++;
                if (p_req) req_age++;
            end

            if (p_flush) begin
                m_pc   = p_ft;
                m_pend = 1'b0;
            end else if (p_valid && !p_stall) begin
                m_pc   = p_redir ? p_rt : (m_pend ? m_pt : m_pc + 32'd4);
                m_pend = 1'b0;
            end else if (p_redir) begin
                m_pend = 1'b1;
                m_pt   = p_rt;
            end

            gap++;
            if (p_flush || (p_valid && !p_stall)) chk("slot_dropped", {31'h0, if_valid}, 32'h0);
            if (if_valid && !p_valid) begin
                slots++;
                gap   = 0;
                e_err = (m_pc[1:0] != 2'b00);
                chk("slot_pc", if_pc, m_pc);
                chk("slot_err", {31'h0, if_addr_error}, {31'h0, e_err});
                chk("slot_ireq", {31'h0, if_inst_req}, {31'h0, !e_err});
                chk("slot_inst", if_inst, e_err ? 32'h0 : mem(m_pc));
            end else if (if_valid && p_valid && p_stall && !p_flush) begin
                chk("hold_pc", if_pc, p_pc);
                chk("hold_inst", if_inst, p_inst);
                chk("hold_err", {31'h0, if_addr_error}, {31'h0, p_err});
                chk("hold_ireq", {31'h0, if_inst_req}, {31'h0, p_ireq});
                chk("hold_no_req", {31'h0, bus.inst_req}, 32'h0);
            end
            if (bus.inst_req && !p_req) begin
                gap = 0;
                chk("req_addr", bus.inst_addr, m_pc);
                chk("req_aligned", {30'h0, bus.inst_addr[1:0]}, 32'h0);
            end else if (p_aok) begin
                chk("req_drop_after_ok", {31'h0, bus.inst_req}, 32'h0);
            end else if (bus.inst_req && p_req) begin
                chk("req_stable", bus.inst_addr, p_addr);
            end
            if (gap > max_gap) max_gap = gap;
        end
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (if_valid !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk(tag, {31'h0, if_valid}, 32'h1);
    endtask

    task automatic wait_req(input string tag, input int max);
        int n = 0;
        while (bus.inst_req !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        chk(tag, {31'h0, bus.inst_req}, 32'h1);
    endtask

    task automatic chk_reset_vals();
        chk("rst_req", {31'h0, bus.inst_req}, 32'h0);
        chk("rst_addr", bus.inst_addr, RESET_PC);
        chk("rst_valid", {31'h0, if_valid}, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);
        chk("rst_err", {31'h0, if_addr_error}, 32'h0);
        chk("rst_ireq", {31'h0, if_inst_req}, 32'h0);
    endtask

    initial begin
        int n;
        reset           = 1'b1;
        stall           = 1'b0;
        flush           = 1'b0;
        flush_target    = 32'h0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        outst     = 1'b0;
        outst_addr = 32'h0;
        req_age   = 0;
        data_age  = 0;
        ad_dly    = 0;
        dd_dly    = 0;
        rand_mode = 1'b0;
        spur_once = 1'b0;
        m_pc      = RESET_PC;
        m_pend    = 1'b0;
        m_pt      = 32'h0;
        slots     = 0;
        gap       = 0;
        max_gap   = 0;

        // reset
        tick();
        tick();
        chk_reset_vals();

        // first fetch, best-case latency
        reset = 1'b0;
        tick();
        chk("first_req", {31'h0, bus.inst_req}, 32'h1);
        chk("first_addr", bus.inst_addr, RESET_PC);
        tick();
        chk("first_not_yet", {31'h0, if_valid}, 32'h0);
        tick();
        chk("first_valid", {31'h0, if_valid}, 32'h1);
        chk("first_pc", if_pc, RESET_PC);
        chk("first_ireq", {31'h0, if_inst_req}, 32'h1);

        // stall holds the slot and blocks new requests
        stall = 1'b1;
        repeat (5) begin
            tick();
            chk("stall_no_req", {31'h0, bus.inst_req}, 32'h0);
            chk("stall_pc", if_pc, RESET_PC);
        end
        stall = 1'b0;
        tick();
        chk("consumed", {31'h0, if_valid}, 32'h0);
        tick();
        chk("second_addr", bus.inst_addr, 32'hBFC0_0004);

        // walk to the delay slot at BFC0_0010
        for (int i = 1; i <= 3; i++) begin
            wait_valid("walk_valid", 10);
            chk("walk_pc", if_pc, RESET_PC + 32'(4 * i));
            tick();
        end
        wait_req("ds_req", 10);
        chk("ds_addr", bus.inst_addr, 32'hBFC0_0010);
        dd_dly = 2;
        tick();
        redirect        = 1'b1;
        redirect_target = 32'h8000_0100;
        tick();
        redirect = 1'b0;
        wait_valid("ds_valid", 10);
        chk("ds_pc", if_pc, 32'hBFC0_0010);
        chk("ds_inst", if_inst, mem(32'hBFC0_0010));
        tick();
        wait_req("br_req", 10);
        chk("br_addr", bus.inst_addr, 32'h8000_0100);

        // flush while in DATA
        tick();
        flush        = 1'b1;
        flush_target = 32'hBFC0_0380;
        tick();
        flush = 1'b0;
        n = 0;
        while (bus.inst_req !== 1'b1 && n < 20) begin
            chk("dflush_no_valid", {31'h0, if_valid}, 32'h0);
            tick();
            n++;
        end
        chk("dflush_req", {31'h0, bus.inst_req}, 32'h1);
        chk("dflush_addr", bus.inst_addr, 32'hBFC0_0380);
        dd_dly = 0;
        wait_valid("exc_valid", 10);
        chk("exc_pc", if_pc, 32'hBFC0_0380);

        // flush while in ADDR, addr_ok held off
        ad_dly = 3;
        tick();
        wait_req("aflush_req", 10);
        chk("aflush_addr0", bus.inst_addr, 32'hBFC0_0384);
        flush        = 1'b1;
        flush_target = 32'hBFC0_0380;
        tick();
        flush = 1'b0;
        chk("aflush_addr1", bus.inst_addr, 32'hBFC0_0384);
        repeat (2) begin
            tick();
            chk("aflush_req_held", {31'h0, bus.inst_req}, 32'h1);
            chk("aflush_addr_held", bus.inst_addr, 32'hBFC0_0384);
        end
        tick();
        ad_dly = 0;
        tick();
        chk("aflush_dropped", {31'h0, if_valid}, 32'h0);
        wait_req("aflush_refetch", 10);
        chk("aflush_refetch_addr", bus.inst_addr, 32'hBFC0_0380);
        wait_valid("aflush_valid", 10);
        chk("aflush_inst", if_inst, mem(32'hBFC0_0380));

        // misaligned flush target
        flush        = 1'b1;
        flush_target = 32'h8000_0002;
        tick();
        flush = 1'b0;
        chk("mis_no_req0", {31'h0, bus.inst_req}, 32'h0);
        tick();
        chk("mis_no_req1", {31'h0, bus.inst_req}, 32'h0);
        chk("mis_valid", {31'h0, if_valid}, 32'h1);
        chk("mis_err", {31'h0, if_addr_error}, 32'h1);
        chk("mis_ireq", {31'h0, if_inst_req}, 32'h0);
        chk("mis_inst", if_inst, 32'h0);
        chk("mis_pc", if_pc, 32'h8000_0002);
        tick();
        tick();
        chk("mis2_pc", if_pc, 32'h8000_0006);
        chk("mis2_no_req", {31'h0, bus.inst_req}, 32'h0);

        // PC wraps at the top of the address space
        flush        = 1'b1;
        flush_target = 32'hFFFF_FFF8;
        tick();
        flush = 1'b0;
        wait_valid("wrap_v0", 10);
        chk("wrap_pc0", if_pc, 32'hFFFF_FFF8);
        tick();
        wait_valid("wrap_v1", 10);
        chk("wrap_pc1", if_pc, 32'hFFFF_FFFC);
        tick();
        wait_req("wrap_req", 10);
        chk("wrap_addr", bus.inst_addr, 32'h0000_0000);

        // reset mid-transaction, then a stray data_ok
        dd_dly = 3;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals();
        spur_once = 1'b1;
        tick();
        chk("post_rst_no_valid", {31'h0, if_valid}, 32'h0);
        chk("post_rst_addr", bus.inst_addr, RESET_PC);
        dd_dly = 0;
        wait_valid("post_rst_valid", 10);
        chk("post_rst_inst", if_inst, mem(RESET_PC));

        // randomized traffic
        rand_mode = 1'b1;
        slots     = 0;
        max_gap   = 0;
        for (int c = 0; c < 3000; c++) begin
            stall           = ($urandom_range(0, 9) < 3);
            redirect        = ($urandom_range(0, 19) == 0);
            redirect_target = $urandom() & 32'hFFFF_FFFC;
            flush           = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 7) == 0) flush_target = $urandom() | 32'h2;
            else                          flush_target = $urandom() & 32'hFFFF_FFFC;
            tick();
        end
        stall    = 1'b0;
        redirect = 1'b0;
        flush    = 1'b0;
        chk("rand_progress", {31'h0, (slots >= 50)}, 32'h1);
        chk("rand_max_gap", {31'h0, (max_gap <= 60)}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
